param_priority_arbiter: RTL and testbench
=========================================

Name: param_priority_arbiter

Overview:
- Parametrised N-requester arbiter; successor to the team's 4-bit fixed-priority arbiter.
- Adds a run-time mode select: fixed priority or round-robin.
- Adds a grant lock, so a requester can hold the resource across cycles.
- Registered one-hot grant plus an encoded grant index. Sits in front of any shared resource (bus, memory port, FIFO write side).

Parameters:
- N, 4, number of requesters (2..32).
- IDW, $clog2(N) (minimum 1), width of GNT_ID.
- RESET_MODE, 0, reserved documentation default for MODE; no RTL effect, since MODE is an input.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- REQ  input  N  request vector; bit i = requester i.
- MODE  input  1  0 = fixed priority, bit 0 highest; 1 = round-robin.
- LOCK  input  N  LOCK[i]=1 with REQ[i]=1 while granted: keep grant on i.
- GNT  output  N  registered one-hot grant, or all-zero.
- GNT_ID  output  IDW  index of granted requester; 0 when GNT_VALID=0.
- GNT_VALID  output  1  OR of GNT.

Behaviour:
- Reset (reset=0, async):
  - GNT=0, GNT_ID=0, GNT_VALID=0.
  - Round-robin pointer PTR=0; owner-locked flag cleared.
  - Takes effect immediately, also mid-lock. The first grant after release is computed from REQ at the first rising edge with reset=1.
- Latency: REQ/LOCK/MODE are sampled at a rising edge; GNT updates at that edge. One-cycle registered latency, no combinational path from REQ to GNT.
- Owner rule: if GNT[i]=1 and REQ[i]=1 and LOCK[i]=1 at the edge, the grant stays on i. No re-arbitration, no PTR update, MODE ignored.
- Otherwise re-arbitrate every cycle:
  - Fixed (MODE=0): lowest-index set bit of REQ wins.
  - Round-robin (MODE=1): search starts at PTR and wraps modulo N. The first set bit of REQ at index >= PTR wins; otherwise the lowest set bit below PTR wins.
- PTR update:
  - On each new grant to index k (either mode), PTR <= (k+1) mod N, so wrap from N-1 goes to 0.
  - PTR holds when no grant is issued or while locked.
- Non-locked holder: a requester that keeps REQ high without LOCK re-competes every cycle. In fixed mode it keeps winning if it has the highest priority. In RR mode it is skipped once others request.
- REQ=0 (all bits): next edge GNT=0, GNT_VALID=0, GNT_ID=0, PTR unchanged.
- Owner drops REQ[i] (LOCK irrelevant): re-arbitrate at that same edge; i may not win, since its REQ is 0.
- LOCK[j] on a non-granted j: ignored.
- MODE change: affects the next unlocked arbitration only. PTR is retained across MODE=0 periods, so RR resumes from the last grant+1.
- Invariants:
  - GNT has at most one bit set.
  - GNT[GNT_ID]=1 whenever GNT_VALID=1.
  - GNT[i]=1 implies REQ[i] was 1 at the granting edge.
- N=1 degenerate: GNT=REQ registered, GNT_ID=0.

Decomposition:
- Shared package arb_pkg:
  - MODE_FIXED=1'b0, MODE_RR=1'b1.
  - Function clog2_min1(n).
  - Function onehot_to_idx (used by the encoder and by the bench checker).
- One combinational sub-module, arb_prio_pick #(N):
  - Inputs: req, start index.
  - Outputs: one-hot winner and valid.
  - Implements wraparound priority via a double-width vector with a mask.
  - Fixed mode instantiates it with start=0.
- Top holds the GNT/PTR registers, lock logic, and index encoder.

Test Plan (N=4):
- Fixed mode: reset low then high, MODE=0, REQ=4'b1010 -> next edge GNT=0010, GNT_ID=1. REQ=1000 -> GNT=1000, GNT_ID=3. REQ=0 -> GNT=0, GNT_VALID=0.
- Round-robin fairness: MODE=1, REQ=1111 held 8 cycles, LOCK=0 -> GNT sequence 0001,0010,0100,1000,0001,... Each requester is granted exactly 2 times.
- Wrap search: MODE=1, previous grant to 2 (PTR=3), REQ=0011 -> GNT=0001, then PTR=1. Next cycle REQ=0011 -> GNT=0010.
- Lock:
  - MODE=1, REQ=0101 -> GNT=0001.
  - LOCK=0001 with REQ held for 5 cycles -> GNT stays 0001.
  - Drop REQ[0] -> next edge GNT=0100.
- Reset mid-lock: GNT=0100 locked, assert reset=0 between edges -> GNT=0, GNT_VALID=0 immediately without a clock edge. Release with REQ=1111, MODE=1 -> first GNT=0001 (PTR=0).
- Mode switch: MODE=1 with grants 0001 then 0010 (PTR=2); switch MODE=0, REQ=0110 -> GNT=0010. Switch back to MODE=1, REQ=0110 -> GNT=0100.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: mode encodings and index helpers shared by the arbiter and its bench
package arb_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR = 1'b1;
  function automatic int clog2_min1(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
  function automatic int onehot_to_idx(input logic [31:0] v);
    int r;
    r = 0;
    for (int i = 31; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction
endpackage

// File: rtl/param_priority_arbiter_if.sv
// param_priority_arbiter_if: request/lock/mode in, registered grant out
interface param_priority_arbiter_if import arb_pkg::*; #(
  parameter int N = 4,
  parameter int IDW = clog2_min1(N)
);
  logic [N-1:0] REQ;
  logic [N-1:0] LOCK;
  logic MODE;
  logic [N-1:0] GNT;
  logic [IDW-1:0] GNT_ID;
  logic GNT_VALID;
  modport master (output REQ, LOCK, MODE, input GNT, GNT_ID, GNT_VALID);
  modport slave (input REQ, LOCK, MODE, output GNT, GNT_ID, GNT_VALID);
endinterface

// File: rtl/arb_prio_pick.sv
// arb_prio_pick: lowest set request at or above start, wrapping modulo N
module arb_prio_pick #(
  parameter int N = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] start,
  output logic [N-1:0]   win,
  output logic           valid
);
  localparam int W = 2 * N;
  logic [W-1:0] dbl, lsb;
  // lower copy masked below start, upper copy intact supplies the wrapped winner
  always_comb begin
    dbl = {req, req} & ({W{1'b1}} << start);
    lsb = dbl & (~dbl + W'(1));
    win = lsb[N-1:0] | lsb[W-1:N];
    valid = |req;
  end
endmodule

// File: rtl/param_priority_arbiter.sv
// param_priority_arbiter: N-way fixed/round-robin arbiter with grant lock
module param_priority_arbiter import arb_pkg::*; #(
  parameter int N = 4,
  parameter int IDW = clog2_min1(N),
  parameter int RESET_MODE = 0
) (
  input logic clk,
  input logic reset,
  param_priority_arbiter_if.slave bus
);
  if (N < 1 || N > 32 || RESET_MODE < 0 || RESET_MODE > 1) begin : g_bad_param
    $error("param_priority_arbiter: unsupported parameters");
  end
  logic [N-1:0] gnt, win_f, win_r, win, nxt;
  logic [IDW-1:0] ptr, gnt_id;
  logic vf, vr, any, hold;
  int win_idx;
  arb_prio_pick #(.N(N), .IDW(IDW)) u_fixed (.req(bus.REQ), .start('0), .win(win_f), .valid(vf));
  arb_prio_pick #(.N(N), .IDW(IDW)) u_rr (.req(bus.REQ), .start(ptr), .win(win_r), .valid(vr));
  // an owner still requesting with LOCK keeps the grant; mode and pointer untouched
  always_comb begin
    hold = |(gnt & bus.REQ & bus.LOCK);
    win = bus.MODE == MODE_RR ? win_r : win_f;
    any = bus.MODE == MODE_RR ? vr : vf;
    nxt = hold ? gnt : win;
    win_idx = onehot_to_idx(32'(win));
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt <= '0;
      gnt_id <= '0;
      ptr <= '0;
    end else begin
      gnt <= nxt;
      gnt_id <= IDW'(onehot_to_idx(32'(nxt)));
      if (!hold && any) ptr <= IDW'(win_idx == N - 1 ? 0 : win_idx + 1);
    end
  end
  assign bus.GNT = gnt;
  assign bus.GNT_ID = gnt_id;
  assign bus.GNT_VALID = |gnt;
endmodule

// File: tb/tb_param_priority_arbiter.sv
// tb_param_priority_arbiter: directed vectors with hand-computed grants, N=4
module tb_param_priority_arbiter;
  import arb_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int assertions = 0;
  int failures = 0;
  int cnt [4];
  param_priority_arbiter_if #(.N(4)) bus ();
  param_priority_arbiter #(.N(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic expect_g(input string tag, input logic [3:0] g);
    check({tag, ".gnt"}, 32'(bus.GNT), 32'(g));
    check({tag, ".id"}, 32'(bus.GNT_ID), 32'(onehot_to_idx(32'(g))));
    check({tag, ".valid"}, 32'(bus.GNT_VALID), 32'(|g));
  endtask
  task automatic cyc(input logic [3:0] r, input logic m, input logic [3:0] l);
    bus.REQ = r;
    bus.MODE = m;
    bus.LOCK = l;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [3:0] rr_seq [8];
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    bus.REQ = 4'b1111;
    bus.MODE = MODE_FIXED;
    bus.LOCK = 4'b1111;
    #3;
    expect_g("reset", 4'b0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    expect_g("reset_held", 4'b0000);
    reset = 1'b1;
    cyc(4'b1010, MODE_FIXED, 4'b0000);
    expect_g("fix_1010", 4'b0010);
    cyc(4'b1000, MODE_FIXED, 4'b0000);
    expect_g("fix_1000", 4'b1000);
    cyc(4'b0000, MODE_FIXED, 4'b0000);
    expect_g("fix_none", 4'b0000);
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(4'b1111, MODE_RR, 4'b0000);
      expect_g($sformatf("rr_%0d", i), rr_seq[i]);
      for (int j = 0; j < 4; j++) if (bus.GNT[j]) cnt[j]++;
    end
    for (int i = 0; i < 4; i++) check($sformatf("rr_count_%0d", i), 32'(cnt[i]), 32'd2);
    cyc(4'b0100, MODE_RR, 4'b0000);
    expect_g("wrap_pre", 4'b0100);
    cyc(4'b0011, MODE_RR, 4'b0000);
    expect_g("wrap_a", 4'b0001);
    cyc(4'b0011, MODE_RR, 4'b0000);
    expect_g("wrap_b", 4'b0010);
    cyc(4'b1000, MODE_RR, 4'b0000);
    expect_g("lock_pre", 4'b1000);
    cyc(4'b0101, MODE_RR, 4'b0000);
    expect_g("lock_first", 4'b0001);
    for (int i = 0; i < 5; i++) begin
      cyc(4'b0101, MODE_RR, 4'b0001);
      expect_g($sformatf("lock_hold_%0d", i), 4'b0001);
    end
    cyc(4'b0100, MODE_RR, 4'b0001);
    expect_g("lock_drop", 4'b0100);
    cyc(4'b1111, MODE_RR, 4'b0100);
    expect_g("lock_again", 4'b0100);
    #2;
    reset = 1'b0;
    #1;
    expect_g("async_reset", 4'b0000);
    cyc(4'b1111, MODE_RR, 4'b0000);
    expect_g("reset_no_clk_grant", 4'b0000);
    reset = 1'b1;
    cyc(4'b1111, MODE_RR, 4'b0000);
    expect_g("post_reset", 4'b0001);
    cyc(4'b1111, MODE_RR, 4'b0000);
    expect_g("mode_rr2", 4'b0010);
    cyc(4'b0110, MODE_FIXED, 4'b0000);
    expect_g("mode_fixed", 4'b0010);
    cyc(4'b0110, MODE_RR, 4'b0000);
    expect_g("mode_back_rr", 4'b0100);
    cyc(4'b0011, MODE_FIXED, 4'b0010);
    expect_g("lock_nongranted", 4'b0001);
    cyc(4'b0001, MODE_FIXED, 4'b0000);
    expect_g("fix_keep_unlocked", 4'b0001);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule
